// File: rtl/arc4_pkg.sv
// Shared ARC4 definitions: memory geometry and the PRGA state encoding.
package arc4_pkg;

    localparam int         MEM_DEPTH = 256;
    localparam logic [7:0] LEN_ADDR  = 8'd0;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_RD_LEN  = 4'd1,
        ST_GET_LEN = 4'd2,
        ST_WR_LEN  = 4'd3,
        ST_RD_I    = 4'd4,
        ST_GET_I   = 4'd5,
        ST_RD_J    = 4'd6,
        ST_GET_J   = 4'd7,
        ST_WR_I    = 4'd8,
        ST_WR_J    = 4'd9,
        ST_RD_PAD  = 4'd10,
        ST_GET_PAD = 4'd11,
        ST_WR_PT   = 4'd12
    } prga_state_t;

endpackage

// File: rtl/prga.sv
// ARC4 pseudo-random generation stage: decrypts a length-prefixed message
// from CT memory into PT memory using the S-box left behind by KSA.
//
// state   | meaning
// --------+------------------------------------------------------
// IDLE    | rdy=1, waiting for en
// RD_LEN  | address ct[0]
// GET_LEN | capture message length L
// WR_LEN  | write pt[0]=L, k=1; done here when L=0
// RD_I    | i=i+1, address S[i]
// GET_I   | capture si, j=j+si
// RD_J    | address S[j]
// GET_J   | capture sj
// WR_I    | S[i]=sj
// WR_J    | S[j]=si, address ct[k]
// RD_PAD  | capture c, address S[si+sj]
// GET_PAD | capture pad
// WR_PT   | pt[k]=pad^c; next byte or IDLE when k==L
module prga
    import arc4_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    output logic              rdy,
    output logic [ADDR_W-1:0] s_addr,
    input  logic [7:0]        s_rddata,
    output logic [7:0]        s_wrdata,
    output logic              s_wren,
    output logic [ADDR_W-1:0] ct_addr,
    input  logic [7:0]        ct_rddata,
    output logic [ADDR_W-1:0] pt_addr,
    input  logic [7:0]        pt_rddata,
    output logic [7:0]        pt_wrdata,
    output logic              pt_wren
);

    prga_state_t       state, state_nx;
    logic [ADDR_W-1:0] i, j, k, len;
    logic [7:0]        si, sj, c, pad;

    // PT read port exists only to keep all memory ports alike
    logic unused_pt;
    assign unused_pt = ^pt_rddata;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:    if (en) state_nx = ST_RD_LEN;
            ST_RD_LEN:  state_nx = ST_GET_LEN;
            ST_GET_LEN: state_nx = ST_WR_LEN;
            ST_WR_LEN:  state_nx = (len == '0) ? ST_IDLE : ST_RD_I;
            ST_RD_I:    state_nx = ST_GET_I;
            ST_GET_I:   state_nx = ST_RD_J;
            ST_RD_J:    state_nx = ST_GET_J;
            ST_GET_J:   state_nx = ST_WR_I;
            ST_WR_I:    state_nx = ST_WR_J;
            ST_WR_J:    state_nx = ST_RD_PAD;
            ST_RD_PAD:  state_nx = ST_GET_PAD;
            ST_GET_PAD: state_nx = ST_WR_PT;
            ST_WR_PT:   state_nx = (k == len) ? ST_IDLE : ST_RD_I;
            default:    state_nx = ST_IDLE;
        endcase
    end

    // Memory port drive; everything idles at zero so reset leaves the ports quiet
    always_comb begin
        rdy       = 1'b0;
        s_addr    = '0;
        s_wrdata  = 8'd0;
        s_wren    = 1'b0;
        ct_addr   = '0;
        pt_addr   = '0;
        pt_wrdata = 8'd0;
        pt_wren   = 1'b0;
        case (state)
            ST_IDLE:   rdy = 1'b1;
            ST_RD_LEN: ct_addr = ADDR_W'(LEN_ADDR);
            ST_WR_LEN: begin
                pt_addr   = ADDR_W'(LEN_ADDR);
                pt_wrdata = 8'(len);
                pt_wren   = 1'b1;
            end
            ST_RD_I:   s_addr = i + 1'b1;
            ST_RD_J:   s_addr = j;
            ST_WR_I: begin
                s_addr   = i;
                s_wrdata = sj;
                s_wren   = 1'b1;
            end
            ST_WR_J: begin
                s_addr   = j;
                s_wrdata = si;
                s_wren   = 1'b1;
                ct_addr  = k;
            end
            ST_RD_PAD: s_addr = ADDR_W'(8'(si + sj));
            ST_WR_PT: begin
                pt_addr   = k;
                pt_wrdata = pad ^ c;
                pt_wren   = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath registers; i/j restart at zero for every message
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i   <= '0;
            j   <= '0;
            k   <= '0;
            len <= '0;
            si  <= 8'd0;
            sj  <= 8'd0;
            c   <= 8'd0;
            pad <= 8'd0;
        end else begin
            case (state)
                ST_IDLE: if (en) begin
                    i <= '0;
                    j <= '0;
                end
                ST_GET_LEN: len <= ADDR_W'(ct_rddata);
                ST_WR_LEN:  k   <= ADDR_W'(1);
                ST_RD_I:    i   <= i + 1'b1;
                ST_GET_I: begin
                    si <= s_rddata;
                    j  <= j + ADDR_W'(s_rddata);
                end
                ST_GET_J:   sj  <= s_rddata;
                ST_RD_PAD:  c   <= ct_rddata;
                ST_GET_PAD: pad <= s_rddata;
                ST_WR_PT:   if (k != len) k <= k + 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_prga.sv
// Directed bench for prga: behavioural S/CT/PT memories, table of messages
// with hand-computed plaintext, plus reset and mid-run en sequences.
module tb_prga;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       rdy;
    logic [7:0] s_addr, s_rddata, s_wrdata;
    logic       s_wren;
    logic [7:0] ct_addr, ct_rddata;
    logic [7:0] pt_addr, pt_rddata, pt_wrdata;
    logic       pt_wren;

    int total = 0;
    int bad   = 0;
    int overlap = 0;

    logic [7:0] s_mem  [0:255];
    logic [7:0] ct_mem [0:255];
    logic [7:0] pt_mem [0:255];
    logic [7:0] load_img [0:255];
    logic       load_s = 1'b0;
    logic       clr_pt = 1'b0;

    always #5 clk = ~clk;

    prga #(.ADDR_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .rdy(rdy),
        .s_addr(s_addr), .s_rddata(s_rddata), .s_wrdata(s_wrdata), .s_wren(s_wren),
        .ct_addr(ct_addr), .ct_rddata(ct_rddata),
        .pt_addr(pt_addr), .pt_rddata(pt_rddata), .pt_wrdata(pt_wrdata), .pt_wren(pt_wren)
    );

    // Synchronous-read memories; bench loads go through the same process
    always @(posedge clk) begin
        s_rddata  <= s_mem[s_addr];
        ct_rddata <= ct_mem[ct_addr];
        pt_rddata <= pt_mem[pt_addr];
        if (load_s) begin
            for (int x = 0; x < 256; x++) s_mem[x] <= load_img[x];
        end else if (s_wren) begin
            s_mem[s_addr] <= s_wrdata;
        end
        if (clr_pt) begin
            for (int x = 0; x < 256; x++) pt_mem[x] <= 8'hAA;
        end else if (pt_wren) begin
            pt_mem[pt_addr] <= pt_wrdata;
        end
    end

    always @(negedge clk) if (s_wren && pt_wren) overlap++;

    typedef struct {
        string      name;
        int         len;
        bit         key_sbox;
        bit         pulse;
        int         cycles;
        logic [7:0] ct [0:15];
        logic [7:0] pt [0:15];
    } vec_t;

    vec_t vecs [5];

    logic [7:0] key_ct [0:8] = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    logic [7:0] key_pt [0:8] = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Reference KSA with key "Key" to build the starting S-box
    task automatic build_sbox(input bit use_key);
        logic [7:0] kb [0:2];
        logic [7:0] jj, t;
        kb[0] = 8'h4B; kb[1] = 8'h65; kb[2] = 8'h79;
        for (int x = 0; x < 256; x++) load_img[x] = 8'(x);
        if (use_key) begin
            jj = 8'd0;
            for (int x = 0; x < 256; x++) begin
                jj = jj + load_img[x] + kb[x % 3];
                t = load_img[x];
                load_img[x] = load_img[jj];
                load_img[jj] = t;
            end
        end
    endtask

    task automatic prep(input int v);
        build_sbox(vecs[v].key_sbox);
        for (int x = 0; x < 256; x++) ct_mem[x] = 8'h00;
        for (int x = 0; x < 16; x++) ct_mem[x] = vecs[v].ct[x];
        @(negedge clk);
        load_s = 1'b1;
        clr_pt = 1'b1;
        @(negedge clk);
        load_s = 1'b0;
        clr_pt = 1'b0;
    endtask

    // Start a run and count cycles from the accepting edge until rdy; abort_at>0 resets mid-run
    task automatic run(input int v, input int abort_at, output int cyc);
        @(negedge clk);
        en = 1'b1;
        @(posedge clk);
        #1 en = 1'b0;
        chk({vecs[v].name, " rdy_drop"}, int'(rdy), 0);
        cyc = 0;
        while (cyc < 5000) begin
            @(posedge clk);
            cyc++;
            #1;
            if (vecs[v].pulse && (cyc == 20 || cyc == 50)) en = 1'b1;
            else en = 1'b0;
            if (abort_at > 0 && cyc == abort_at) begin
                #2 rst_n = 1'b0;
                #1;
                chk("abort rdy", int'(rdy), 1);
                chk("abort s_wren", int'(s_wren), 0);
                chk("abort pt_wren", int'(pt_wren), 0);
                chk("abort s_addr", int'(s_addr), 0);
                en = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            if (rdy) break;
        end
        en = 1'b0;
        if (cyc >= 5000) chk({vecs[v].name, " timeout"}, cyc, -1);
    endtask

    task automatic check_pt(input int v);
        for (int x = 0; x <= vecs[v].len; x++)
            chk($sformatf("%s pt[%0d]", vecs[v].name, x), int'(pt_mem[x]), int'(vecs[v].pt[x]));
        chk({vecs[v].name, " pt_tail"}, int'(pt_mem[vecs[v].len + 1]), 'hAA);
    endtask

    initial begin
        int cyc;

        for (int v = 0; v < 5; v++) begin
            for (int x = 0; x < 16; x++) begin
                vecs[v].ct[x] = 8'h00;
                vecs[v].pt[x] = 8'h00;
            end
            vecs[v].pulse = 1'b0;
        end
        // empty message
        vecs[0].name = "len0"; vecs[0].len = 0; vecs[0].key_sbox = 1'b0; vecs[0].cycles = 3;
        // identity S, one byte: i=j=1 self-swap, pad=S[2]=2
        vecs[1].name = "ident1"; vecs[1].len = 1; vecs[1].key_sbox = 1'b0; vecs[1].cycles = 12;
        vecs[1].ct[0] = 8'd1; vecs[1].ct[1] = 8'h00;
        vecs[1].pt[0] = 8'd1; vecs[1].pt[1] = 8'h02;
        // identity S, two bytes: second byte swaps S[2],S[3] and pads with S[5]=5
        vecs[2].name = "ident2"; vecs[2].len = 2; vecs[2].key_sbox = 1'b0; vecs[2].cycles = 21;
        vecs[2].ct[0] = 8'd2; vecs[2].ct[1] = 8'h10; vecs[2].ct[2] = 8'h20;
        vecs[2].pt[0] = 8'd2; vecs[2].pt[1] = 8'h12; vecs[2].pt[2] = 8'h25;
        // KSA("Key") message, and the same with stray en pulses mid-run
        for (int v = 3; v < 5; v++) begin
            vecs[v].len = 9; vecs[v].key_sbox = 1'b1; vecs[v].cycles = 84;
            vecs[v].ct[0] = 8'd9; vecs[v].pt[0] = 8'd9;
            for (int x = 0; x < 9; x++) begin
                vecs[v].ct[x+1] = key_ct[x];
                vecs[v].pt[x+1] = key_pt[x];
            end
        end
        vecs[3].name = "key9";
        vecs[4].name = "key9_pulse"; vecs[4].pulse = 1'b1;

        rst_n = 1'b0;
        en    = 1'b0;
        #12;
        chk("reset rdy", int'(rdy), 1);
        chk("reset s_wren", int'(s_wren), 0);
        chk("reset pt_wren", int'(pt_wren), 0);
        chk("reset addrs", int'(s_addr) + int'(ct_addr) + int'(pt_addr), 0);
        chk("reset wrdata", int'(s_wrdata) + int'(pt_wrdata), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 5; v++) begin
            prep(v);
            run(v, 0, cyc);
            chk({vecs[v].name, " cycles"}, cyc, vecs[v].cycles);
            check_pt(v);
            if (v == 1) begin
                for (int x = 0; x < 4; x++)
                    chk($sformatf("ident1 S[%0d]", x), int'(s_mem[x]), x);
            end
        end

        // Reset during byte 4, then reload and rerun
        prep(3);
        run(3, 3 + 3*9 + 4, cyc);
        @(negedge clk);
        chk("post_abort rdy", int'(rdy), 1);
        prep(3);
        run(3, 0, cyc);
        chk("rerun cycles", cyc, 84);
        check_pt(3);

        chk("wren overlap", overlap, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
